// File: rtl/isa_pkg.sv
// Shared types for the instruction-execution sequencer:
// unit indices, FSM encoding and fault codes.
package isa_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_RELEASE,
        S_COMMIT,
        S_FAULT
    } state_e;

    localparam logic [1:0] FC_NONE    = 2'd0;
    localparam logic [1:0] FC_ILLEGAL = 2'd1;
    localparam logic [1:0] FC_TIMEOUT = 2'd2;

    localparam int UNIT_BR  = 0;
    localparam int UNIT_LD  = 1;
    localparam int UNIT_ST  = 2;
    localparam int UNIT_ALU = 3;
    localparam int UNIT_MUL = 4;
    localparam int UNIT_CSR = 5;
    localparam int UNIT_JMP = 6;
    localparam int UNIT_SYS = 7;

    function automatic int op_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/isa_exec_ctrl_if.sv
// Decoder, execution-unit and register-file signals of the
// sequencer; master is the controller side.
interface isa_exec_ctrl_if #(
    parameter int N_UNITS = 8,
    parameter int IP_W    = 64
);
    import isa_pkg::*;

    localparam int OP_W = op_width(N_UNITS);

    logic                      insn_valid;
    logic [OP_W-1:0]           insn_op;
    logic                      insn_ready;
    logic [N_UNITS-1:0]        unit_en;
    logic [N_UNITS-1:0]        unit_finished;
    logic [N_UNITS-1:0]        unit_reg_re;
    logic [4*N_UNITS-1:0]      unit_reg_id;
    logic [N_UNITS-1:0]        unit_ip_set;
    logic [IP_W*N_UNITS-1:0]   unit_ip_val;
    logic                      rf_re;
    logic [3:0]                rf_id;
    logic [IP_W-1:0]           ip;
    logic                      ip_valid;
    logic                      fault;
    logic [1:0]                fault_code;

    modport master (
        input  insn_valid, insn_op,
        input  unit_finished, unit_reg_re, unit_reg_id,
        input  unit_ip_set, unit_ip_val,
        output insn_ready, unit_en, rf_re, rf_id,
        output ip, ip_valid, fault, fault_code
    );

    modport slave (
        output insn_valid, insn_op,
        output unit_finished, unit_reg_re, unit_reg_id,
        output unit_ip_set, unit_ip_val,
        input  insn_ready, unit_en, rf_re, rf_id,
        input  ip, ip_valid, fault, fault_code
    );

endinterface

// File: rtl/isa_unit_mux.sv
// Picks one execution unit's request signals by index;
// an out-of-range index yields all zeros.
module isa_unit_mux
    import isa_pkg::*;
#(
    parameter int N_UNITS = 8,
    parameter int IP_W    = 64,
    parameter int OP_W    = op_width(N_UNITS)
) (
    input  logic [OP_W-1:0]         sel_i,
    input  logic [N_UNITS-1:0]      finished_i,
    input  logic [N_UNITS-1:0]      reg_re_i,
    input  logic [4*N_UNITS-1:0]    reg_id_i,
    input  logic [N_UNITS-1:0]      ip_set_i,
    input  logic [IP_W*N_UNITS-1:0] ip_val_i,
    output logic                    finished_o,
    output logic                    reg_re_o,
    output logic [3:0]              reg_id_o,
    output logic                    ip_set_o,
    output logic [IP_W-1:0]         ip_val_o
);

    always_comb begin
        finished_o = 1'b0;
        reg_re_o   = 1'b0;
        reg_id_o   = '0;
        ip_set_o   = 1'b0;
        ip_val_o   = '0;
        for (int k = 0; k < N_UNITS; k++) begin
            if (sel_i == OP_W'(k)) begin
                finished_o = finished_i[k];
                reg_re_o   = reg_re_i[k];
                reg_id_o   = reg_id_i[4*k +: 4];
                ip_set_o   = ip_set_i[k];
                ip_val_o   = ip_val_i[IP_W*k +: IP_W];
            end
        end
    end

endmodule

// File: rtl/isa_exec_ctrl.sv
// Sequences one decoded instruction through its execution unit
// and commits the next instruction pointer.
module isa_exec_ctrl
    import isa_pkg::*;
#(
    parameter int              N_UNITS  = 8,
    parameter int              IP_W     = 64,
    parameter int              INSN_LEN = 2,
    parameter logic [IP_W-1:0] RESET_IP = '0,
    parameter int              TIMEOUT  = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    isa_exec_ctrl_if.master bus
);

    localparam int OP_W  = op_width(N_UNITS);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [OP_W:0]    N_LIM = (OP_W + 1)'(N_UNITS);
    localparam logic [CNT_W-1:0] TO_V  = CNT_W'(TIMEOUT);

    state_e            state_q;
    logic [OP_W-1:0]   op_q;
    logic              taken_q;
    logic [IP_W-1:0]   target_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [IP_W-1:0]   ip_q;
    logic [IP_W-1:0]   ip_d;
    logic              ip_valid_q;
    logic              fault_q;
    logic [1:0]        fc_q;

    logic              exec;
    logic              sel_fin;
    logic              sel_re;
    logic [3:0]        sel_id;
    logic              sel_set;
    logic [IP_W-1:0]   sel_val;
    logic [N_UNITS-1:0] en_c;

    isa_unit_mux #(
        .N_UNITS (N_UNITS),
        .IP_W    (IP_W),
        .OP_W    (OP_W)
    ) u_mux (
        .sel_i      (op_q),
        .finished_i (bus.unit_finished),
        .reg_re_i   (bus.unit_reg_re),
        .reg_id_i   (bus.unit_reg_id),
        .ip_set_i   (bus.unit_ip_set),
        .ip_val_i   (bus.unit_ip_val),
        .finished_o (sel_fin),
        .reg_re_o   (sel_re),
        .reg_id_o   (sel_id),
        .ip_set_o   (sel_set),
        .ip_val_o   (sel_val)
    );

    assign exec  = (state_q == S_EXEC);
    assign cnt_d = cnt_q + CNT_W'(1);
    assign ip_d  = taken_q ? target_q : ip_q + IP_W'(INSN_LEN);

    // Enable decoded from state so an async reset drops it at once.
    always_comb begin
        en_c = '0;
        for (int k = 0; k < N_UNITS; k++) begin
            en_c[k] = exec && (op_q == OP_W'(k));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            taken_q    <= 1'b0;
            target_q   <= '0;
            cnt_q      <= '0;
            ip_q       <= RESET_IP;
            ip_valid_q <= 1'b0;
            fault_q    <= 1'b0;
            fc_q       <= FC_NONE;
        end else begin
            ip_valid_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (bus.insn_valid) begin
                        if ({1'b0, bus.insn_op} < N_LIM) begin
                            op_q    <= bus.insn_op;
                            taken_q <= 1'b0;
                            cnt_q   <= '0;
                            state_q <= S_EXEC;
                        end else begin
                            fault_q <= 1'b1;
                            fc_q    <= FC_ILLEGAL;
                            state_q <= S_FAULT;
                        end
                    end
                end
                S_EXEC: begin
                    cnt_q <= cnt_d;
                    if (sel_set) begin
                        taken_q  <= 1'b1;
                        target_q <= sel_val;
                    end
                    if (sel_fin) begin
                        state_q <= S_RELEASE;
                    end else if (cnt_d == TO_V) begin
                        fault_q <= 1'b1;
                        fc_q    <= FC_TIMEOUT;
                        state_q <= S_FAULT;
                    end
                end
                // Load ip here so it is already valid during COMMIT.
                S_RELEASE: begin
                    ip_q       <= ip_d;
                    ip_valid_q <= 1'b1;
                    state_q    <= S_COMMIT;
                end
                S_COMMIT: state_q <= S_IDLE;
                S_FAULT:  state_q <= S_FAULT;
                default:  state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.insn_ready = (state_q == S_IDLE);
    assign bus.unit_en    = en_c;
    assign bus.rf_re      = exec & sel_re;
    assign bus.rf_id      = exec ? sel_id : 4'd0;
    assign bus.ip         = ip_q;
    assign bus.ip_valid   = ip_valid_q;
    assign bus.fault      = fault_q;
    assign bus.fault_code = fc_q;

endmodule

// File: tb/tb_isa_exec_ctrl.sv
// Scoreboarded bench for isa_exec_ctrl: expected IPs queued at
// issue, checked when ip_valid pulses.
module tb_isa_exec_ctrl;
    import isa_pkg::*;

    localparam int          NU  = 6;
    localparam int          IPW = 64;
    localparam int          TO  = 10;
    localparam logic [63:0] RIP = 64'h100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    isa_exec_ctrl_if #(.N_UNITS(NU), .IP_W(IPW)) bus ();

    isa_exec_ctrl #(
        .N_UNITS  (NU),
        .IP_W     (IPW),
        .INSN_LEN (2),
        .RESET_IP (RIP),
        .TIMEOUT  (TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] exp_q[$];
    logic [63:0] m_ip;
    logic [63:0] mon_exp;

    always @(negedge clk) begin
        if (rst_n && bus.ip_valid === 1'b1) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL ip_commit unexpected pulse ip=%h", bus.ip);
            end else begin
                mon_exp = exp_q.pop_front();
                if (bus.ip !== mon_exp) begin
                    n_fail++;
                    $display("FAIL ip_commit got %h exp %h", bus.ip, mon_exp);
                end
            end
        end
    end

    task automatic clear_units();
        bus.insn_valid    = 1'b0;
        bus.insn_op       = '0;
        bus.unit_finished = '0;
        bus.unit_reg_re   = '0;
        bus.unit_reg_id   = '0;
        bus.unit_ip_set   = '0;
        bus.unit_ip_val   = '0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        clear_units();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_ip  = RIP;
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_units();
        @(negedge clk);
        n_tests++;
        if ({bus.insn_ready, bus.unit_en, bus.rf_re, bus.rf_id}
            !== {1'b1, 6'b0, 1'b0, 4'd0}) begin
            n_fail++;
            $display("FAIL reset_ctl got %b", {bus.insn_ready,
                     bus.unit_en, bus.rf_re, bus.rf_id});
        end
        n_tests++;
        if ({bus.ip, bus.ip_valid, bus.fault, bus.fault_code}
            !== {RIP, 1'b0, 1'b0, 2'd0}) begin
            n_fail++;
            $display("FAIL reset_ip got ip=%h v=%b f=%b c=%0d exp ip=%h",
                     bus.ip, bus.ip_valid, bus.fault, bus.fault_code, RIP);
        end
        @(negedge clk);
        rst_n = 1'b1;
        m_ip  = RIP;
    endtask

    task automatic exec_insn(input int op, input int fin,
                             input int set1, input logic [63:0] v1,
                             input int set2, input logic [63:0] v2,
                             input int rd, input logic [3:0] rid,
                             input bit noise, input string nm);
        int          w = 0;
        int          o;
        logic [5:0]  oh;
        logic [63:0] e;
        while (bus.insn_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        n_tests++;
        if (bus.insn_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s ready_wait got %b exp 1", nm, bus.insn_ready);
        end
        oh = 6'b1 << op;
        o  = (op + 1) % NU;
        e  = (set2 > 0) ? v2 : (set1 > 0) ? v1 : m_ip + 64'd2;
        exp_q.push_back(e);
        m_ip = e;
        bus.insn_valid = 1'b1;
        bus.insn_op    = 3'(op);
        @(negedge clk);
        bus.insn_valid = 1'b0;
        for (int c = 1; c <= fin; c++) begin
            n_tests++;
            if (bus.unit_en !== oh) begin
                n_fail++;
                $display("FAIL %s unit_en cyc%0d got %b exp %b",
                         nm, c, bus.unit_en, oh);
            end
            bus.unit_finished = (c == fin) ? oh : 6'b0;
            bus.unit_ip_set   = (c == set1 || c == set2) ? oh : 6'b0;
            bus.unit_reg_re   = (c == rd) ? oh : 6'b0;
            bus.unit_ip_val   = '0;
            bus.unit_ip_val[op*64 +: 64] = (c == set2) ? v2 : v1;
            bus.unit_reg_id   = '0;
            bus.unit_reg_id[op*4 +: 4] = rid;
            if (noise) begin
                bus.unit_finished[o]      = 1'b1;
                bus.unit_ip_set[o]        = 1'b1;
                bus.unit_reg_re[o]        = 1'b1;
                bus.unit_ip_val[o*64 +: 64] = 64'h40;
                bus.unit_reg_id[o*4 +: 4] = 4'hF;
            end
            #1;
            n_tests++;
            if ({bus.rf_re, bus.rf_id} !== {c == rd, rid}) begin
                n_fail++;
                $display("FAIL %s rf cyc%0d got %b/%0d exp %b/%0d", nm, c,
                         bus.rf_re, bus.rf_id, c == rd, rid);
            end
            @(negedge clk);
        end
        clear_units();
        n_tests++;
        if ({bus.unit_en, bus.rf_re, bus.ip_valid} !== 8'b0) begin
            n_fail++;
            $display("FAIL %s release got en=%b re=%b v=%b exp 0",
                     nm, bus.unit_en, bus.rf_re, bus.ip_valid);
        end
        @(negedge clk);
        n_tests++;
        if ({bus.unit_en, bus.ip_valid} !== 7'b1) begin
            n_fail++;
            $display("FAIL %s commit got en=%b v=%b exp en=0 v=1",
                     nm, bus.unit_en, bus.ip_valid);
        end
        @(negedge clk);
        n_tests++;
        if ({bus.ip_valid, bus.insn_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL %s post_commit got v=%b rdy=%b exp v=0 rdy=1",
                     nm, bus.ip_valid, bus.insn_ready);
        end
    endtask

    task automatic test_fall_through();
        exec_insn(UNIT_ALU, 3, 0, 64'h0, 0, 64'h0, 0, 4'd0, 1'b0, "fall");
    endtask

    task automatic test_branch();
        exec_insn(UNIT_BR, 2, 2, 64'hDEAD0000, 0, 64'h0,
                  2, 4'd5, 1'b0, "branch");
    endtask

    task automatic test_isolation();
        exec_insn(UNIT_LD, 2, 0, 64'h0, 0, 64'h0, 1, 4'd3, 1'b1, "iso");
    endtask

    task automatic test_back_to_back();
        exec_insn(UNIT_MUL, 3, 1, 64'h3000, 2, 64'h4000,
                  0, 4'd1, 1'b0, "b2b_ovr");
        exec_insn(UNIT_ST, 1, 0, 64'h0, 0, 64'h0, 1, 4'd9, 1'b0, "b2b_st");
        exec_insn(UNIT_CSR, 1, 0, 64'h0, 0, 64'h0, 0, 4'd0, 1'b1, "b2b_csr");
    endtask

    task automatic test_wrap();
        exec_insn(UNIT_BR, 1, 1, 64'hFFFF_FFFF_FFFF_FFFE, 0, 64'h0,
                  0, 4'd0, 1'b0, "wrap_br0");
        exec_insn(UNIT_ALU, 1, 0, 64'h0, 0, 64'h0, 0, 4'd0, 1'b0, "wrap0");
        exec_insn(UNIT_BR, 1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 64'h0,
                  0, 4'd0, 1'b0, "wrap_br1");
        exec_insn(UNIT_ALU, 1, 0, 64'h0, 0, 64'h0, 0, 4'd0, 1'b0, "wrap1");
    endtask

    task automatic test_timeout();
        logic [5:0] oh;
        oh = 6'b1 << UNIT_ST;
        bus.insn_valid = 1'b1;
        bus.insn_op    = 3'(UNIT_ST);
        @(negedge clk);
        bus.insn_valid = 1'b0;
        for (int c = 1; c <= TO; c++) begin
            n_tests++;
            if ({bus.unit_en, bus.fault} !== {oh, 1'b0}) begin
                n_fail++;
                $display("FAIL timeout_exec cyc%0d got en=%b f=%b exp en=%b",
                         c, bus.unit_en, bus.fault, oh);
            end
            @(negedge clk);
        end
        n_tests++;
        if ({bus.fault, bus.fault_code, bus.unit_en, bus.insn_ready}
            !== {1'b1, FC_TIMEOUT, 6'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL timeout_fault got f=%b c=%0d en=%b rdy=%b",
                     bus.fault, bus.fault_code, bus.unit_en, bus.insn_ready);
        end
        apply_reset();
    endtask

    task automatic test_illegal();
        bus.insn_valid = 1'b1;
        bus.insn_op    = 3'd7;
        @(negedge clk);
        n_tests++;
        if ({bus.fault, bus.fault_code, bus.unit_en, bus.insn_ready}
            !== {1'b1, FC_ILLEGAL, 6'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL illegal_fault got f=%b c=%0d en=%b rdy=%b",
                     bus.fault, bus.fault_code, bus.unit_en, bus.insn_ready);
        end
        bus.insn_op = 3'(UNIT_ALU);
        repeat (4) @(negedge clk);
        n_tests++;
        if ({bus.fault, bus.fault_code, bus.unit_en, bus.insn_ready, bus.ip}
            !== {1'b1, FC_ILLEGAL, 6'b0, 1'b0, m_ip}) begin
            n_fail++;
            $display("FAIL illegal_sticky got f=%b c=%0d en=%b rdy=%b ip=%h",
                     bus.fault, bus.fault_code, bus.unit_en,
                     bus.insn_ready, bus.ip);
        end
        apply_reset();
        n_tests++;
        if ({bus.fault, bus.fault_code, bus.insn_ready} !== 4'b0001) begin
            n_fail++;
            $display("FAIL illegal_cleared got f=%b c=%0d rdy=%b",
                     bus.fault, bus.fault_code, bus.insn_ready);
        end
    endtask

    task automatic test_async_reset();
        logic [5:0] oh;
        exec_insn(UNIT_JMP % NU, 1, 1, 64'h5000, 0, 64'h0,
                  0, 4'd0, 1'b0, "pre_async");
        oh = 6'b1 << UNIT_ALU;
        bus.insn_valid = 1'b1;
        bus.insn_op    = 3'(UNIT_ALU);
        @(negedge clk);
        bus.insn_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({bus.unit_en, bus.ip} !== {oh, 64'h5000}) begin
            n_fail++;
            $display("FAIL async_pre got en=%b ip=%h exp en=%b ip=5000",
                     bus.unit_en, bus.ip, oh);
        end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({bus.unit_en, bus.ip, bus.insn_ready} !== {6'b0, RIP, 1'b1}) begin
            n_fail++;
            $display("FAIL async_reset got en=%b ip=%h rdy=%b exp en=0 ip=%h",
                     bus.unit_en, bus.ip, bus.insn_ready, RIP);
        end
        @(negedge clk);
        rst_n = 1'b1;
        m_ip  = RIP;
        exp_q.delete();
        exec_insn(UNIT_ALU, 2, 0, 64'h0, 0, 64'h0, 0, 4'd0, 1'b0, "post_async");
    endtask

    initial begin
        clear_units();
        test_reset();
        test_fall_through();
        test_branch();
        test_isolation();
        test_back_to_back();
        test_wrap();
        test_timeout();
        test_illegal();
        test_async_reset();
        repeat (2) @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got %0d pending exp 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
